// File: rtl/neuron_pkg.sv
// neuron_pkg
//   Shared definitions for the streaming neuron MAC: FSM state encoding,
//   derived-width helpers, configuration sanity helpers and the output
//   saturation function.
package neuron_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic signed [63:0] value;
        logic               sat;
    } sat_t;

    function automatic int beats_of(input int n_inputs, input int lanes);
        return n_inputs / lanes;
    endfunction

    function automatic int lane_sum_w(input int data_w, input int lanes);
        return 2 * data_w + $clog2(lanes);
    endfunction

    function automatic int acc_w_min(input int data_w, input int n_inputs);
        return 2 * data_w + $clog2(n_inputs) + 1;
    endfunction

    function automatic bit lanes_divide(input int n_inputs, input int lanes);
        return (lanes > 0) && ((n_inputs % lanes) == 0);
    endfunction

    // value holds an in_w-bit signed quantity sign-extended to 64 bits.
    // Clamps to the out_w-bit signed range and flags whether it had to.
    function automatic sat_t saturate(input logic signed [63:0] value,
                                      input int in_w, input int out_w);
        sat_t               r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi      = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo      = -hi - 64'sd1;
        r.value = value;
        r.sat   = 1'b0;
        if (in_w > out_w) begin
            if (value > hi) begin
                r.value = hi;
                r.sat   = 1'b1;
            end else if (value < lo) begin
                r.value = lo;
                r.sat   = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/neuron_stream_mac_if.sv
// neuron_stream_mac_if
//   Beat input stream (valid/ready, x/w lanes, per-vector config) and the
//   backpressured result port of the streaming neuron MAC.
//   master: upstream fetch logic + downstream consumer side.
//   slave : the MAC itself.
interface neuron_stream_mac_if #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int OUT_W  = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*DATA_W-1:0]   x_vec;
    logic [LANES*DATA_W-1:0]   w_vec;
    logic [DATA_W-1:0]         bias;
    logic [4:0]                shift;
    logic                      use_relu;
    logic                      out_valid;
    logic                      out_ready;
    logic [OUT_W-1:0]          out_data;
    logic                      out_sat;

    modport master (
        output in_valid, x_vec, w_vec, bias, shift, use_relu, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, x_vec, w_vec, bias, shift, use_relu, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/neuron_stream_mac_lane_dot.sv
// lane_dot
//   Combinational LANES-wide signed dot product: one full-precision
//   multiplier per lane followed by a sign-extending adder chain.
//   x_vec, w_vec : packed signed lanes, lane 0 in the LSBs
//   sum          : signed lane sum, wide enough that it cannot overflow
module lane_dot
    import neuron_pkg::*;
#(
    parameter int  DATA_W = 8,
    parameter int  LANES  = 4,
    localparam int LS_W   = lane_sum_w(DATA_W, LANES)
) (
    input  logic [LANES*DATA_W-1:0] x_vec,
    input  logic [LANES*DATA_W-1:0] w_vec,
    output logic signed [LS_W-1:0]  sum
);

    always_comb begin
        logic signed [2*DATA_W-1:0] prod;
        prod = '0;
        sum  = '0;
        for (int i = 0; i < LANES; i++) begin
            prod = $signed(x_vec[i*DATA_W +: DATA_W]) * $signed(w_vec[i*DATA_W +: DATA_W]);
            sum  = sum + LS_W'(prod);
        end
    end

endmodule

// File: rtl/neuron_stream_mac.sv
// neuron_stream_mac
//   Time-multiplexed neuron: accumulates an N_INPUTS dot product delivered
//   as LANES-wide beats, adds a bias, arithmetic-shifts right, saturates to
//   OUT_W and optionally applies ReLU. The result is held until accepted.
//   clk   : clock
//   reset : synchronous, active-low
//   bus   : beat input stream, per-vector config and result port
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   ACCUM | accepting beats; leaves after the last beat of the vector
//   FLUSH | input closed; draining the lane-sum and accumulator stages
//   HOLD  | result presented with out_valid until out_ready handshake
module neuron_stream_mac
    import neuron_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int LANES    = 4,
    parameter int N_INPUTS = 16,
    parameter int ACC_W    = 24,
    parameter int OUT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    neuron_stream_mac_if.slave bus
);

    localparam int BEATS = beats_of(N_INPUTS, LANES);
    localparam int LS_W  = lane_sum_w(DATA_W, LANES);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (!lanes_divide(N_INPUTS, LANES)) begin : g_bad_lanes
        $error("neuron_stream_mac: LANES must divide N_INPUTS");
    end
    if (ACC_W < acc_w_min(DATA_W, N_INPUTS) || ACC_W > 64) begin : g_bad_acc
        $error("neuron_stream_mac: ACC_W out of range for DATA_W/N_INPUTS");
    end

    state_t                   state;
    state_t                   state_nxt;
    logic [CNT_W-1:0]         beat_cnt;
    logic                     accept;
    logic                     beat_first;
    logic                     beat_last;

    logic signed [LS_W-1:0]   lane_sum;
    logic signed [LS_W-1:0]   s1_sum;
    logic                     s1_valid;
    logic                     s1_first;
    logic                     s1_last;

    logic signed [ACC_W-1:0]  acc;
    logic                     acc_done;
    logic signed [DATA_W-1:0] bias_q;
    logic [4:0]               shift_q;
    logic                     relu_q;

    logic signed [ACC_W-1:0]  shifted;
    sat_t                     sat_r;
    logic signed [63:0]       sat_val;
    logic [OUT_W-1:0]         res_data_nxt;
    logic [OUT_W-1:0]         res_data;
    logic                     res_sat;
    logic                     res_valid;

    assign accept     = bus.in_valid && reset && (state == ACCUM);
    assign beat_first = (beat_cnt == '0);
    assign beat_last  = (beat_cnt == CNT_W'(BEATS - 1));

    lane_dot #(
        .DATA_W (DATA_W),
        .LANES  (LANES)
    ) u_lane_dot (
        .x_vec (bus.x_vec),
        .w_vec (bus.w_vec),
        .sum   (lane_sum)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            ACCUM: begin
                bus.in_ready = reset;
                if (accept && beat_last) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (res_valid) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                bus.out_valid = reset;
                if (bus.out_ready) begin
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    // Result path: shift, clamp, then ReLU on the clamped value so that a
    // negative overflow still reports out_sat even though the data reads 0.
    always_comb begin
        shifted      = acc >>> shift_q;
        sat_r        = saturate(64'(shifted), ACC_W, OUT_W);
        sat_val      = sat_r.value;
        res_data_nxt = sat_val[OUT_W-1:0];
        if (relu_q && (sat_val < 64'sd0)) begin
            res_data_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            beat_cnt  <= '0;
            s1_valid  <= 1'b0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            s1_sum    <= '0;
            acc       <= '0;
            acc_done  <= 1'b0;
            bias_q    <= '0;
            shift_q   <= '0;
            relu_q    <= 1'b0;
            res_data  <= '0;
            res_sat   <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            s1_valid  <= accept;
            acc_done  <= 1'b0;
            res_valid <= 1'b0;

            if (accept) begin
                beat_cnt <= beat_last ? '0 : beat_cnt + CNT_W'(1);
                s1_sum   <= lane_sum;
                s1_first <= beat_first;
                s1_last  <= beat_last;
                if (beat_first) begin
                    bias_q  <= $signed(bus.bias);
                    shift_q <= bus.shift;
                    relu_q  <= bus.use_relu;
                end
            end

            if (s1_valid) begin
                if (s1_first) begin
                    acc <= ACC_W'(bias_q) + ACC_W'(s1_sum);
                end else begin
                    acc <= acc + ACC_W'(s1_sum);
                end
                acc_done <= s1_last;
            end

            if (acc_done) begin
                res_data  <= res_data_nxt;
                res_sat   <= sat_r.sat;
                res_valid <= 1'b1;
            end
        end
    end

    assign bus.out_data = res_data;
    assign bus.out_sat  = res_sat;

endmodule

// File: tb/tb_neuron_stream_mac.sv
// tb_neuron_stream_mac
//   Directed vectors with hand-computed results for neuron_stream_mac
//   (DATA_W=8, LANES=4, N_INPUTS=16, ACC_W=24, OUT_W=16).
module tb_neuron_stream_mac;

    localparam int DATA_W   = 8;
    localparam int LANES    = 4;
    localparam int N_INPUTS = 16;
    localparam int ACC_W    = 24;
    localparam int OUT_W    = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    neuron_stream_mac_if #(.DATA_W(DATA_W), .LANES(LANES), .OUT_W(OUT_W)) bus ();

    neuron_stream_mac #(
        .DATA_W   (DATA_W),
        .LANES    (LANES),
        .N_INPUTS (N_INPUTS),
        .ACC_W    (ACC_W),
        .OUT_W    (OUT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input int x, input int w);
        logic [DATA_W-1:0] xb;
        logic [DATA_W-1:0] wb;
        xb = DATA_W'(x);
        wb = DATA_W'(w);
        bus.in_valid = 1'b1;
        bus.x_vec    = {LANES{xb}};
        bus.w_vec    = {LANES{wb}};
    endtask

    // One full vector. bias/shift/relu are only correct on the first beat;
    // later beats carry junk config that must be ignored.
    task automatic run_vector(input string tag, input int x, input int w,
                              input int b, input int sh, input bit relu,
                              input bit gaps, input int hold,
                              input int exp_data, input bit exp_sat);
        int edges;
        bus.out_ready = (hold == 0);
        check({tag, "_in_ready_start"}, int'(bus.in_ready), 1);
        for (int i = 0; i < N_INPUTS / LANES; i++) begin
            drive_beat(x, w);
            if (i == 0) begin
                bus.bias     = DATA_W'(b);
                bus.shift    = 5'(sh);
                bus.use_relu = relu;
            end else begin
                bus.bias     = 8'h55;
                bus.shift    = 5'd9;
                bus.use_relu = ~relu;
            end
            tick();
            if (gaps && i < N_INPUTS / LANES - 1) begin
                bus.in_valid = 1'b0;
                bus.x_vec    = '1;
                tick();
            end
        end
        bus.in_valid = 1'b0;

        edges = 0;
        while (!bus.out_valid && edges < 20) begin
            tick();
            edges++;
        end
        check({tag, "_latency"}, edges, 3);
        check({tag, "_data"}, int'($signed(bus.out_data)), exp_data);
        check({tag, "_sat"}, int'(bus.out_sat), int'(exp_sat));

        for (int c = 0; c < hold; c++) begin
            tick();
            check({tag, "_hold_valid"}, int'(bus.out_valid), 1);
            check({tag, "_hold_data"}, int'($signed(bus.out_data)), exp_data);
            check({tag, "_hold_in_ready"}, int'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        tick();
        check({tag, "_after_hs_valid"}, int'(bus.out_valid), 0);
        check({tag, "_after_hs_in_ready"}, int'(bus.in_ready), 1);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        bus.in_valid  = 1'b0;
        bus.x_vec     = '0;
        bus.w_vec     = '0;
        bus.bias      = '0;
        bus.shift     = '0;
        bus.use_relu  = 1'b0;
        bus.out_ready = 1'b0;

        reset = 1'b0;
        tick();
        tick();
        check("rst_in_ready", int'(bus.in_ready), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_data", int'(bus.out_data), 0);
        check("rst_out_sat", int'(bus.out_sat), 0);
        reset = 1'b1;
        #1;

        //         tag            x     w    bias sh relu gap hold  data    sat
        run_vector("ones",          1,    1,   0,  0, 0,  0,  0,     16,   0);
        run_vector("pos_sat",     127,  127, 127,  0, 0,  0,  0,  32767,   1);
        run_vector("neg_sat",    -128,  127,   0,  0, 0,  0,  0, -32768,   1);
        run_vector("neg_relu",   -128,  127,   0,  0, 1,  0,  0,      0,   1);
        run_vector("shift_pos",     3,    5,  -7,  2, 0,  0,  0,     58,   0);
        run_vector("shift_neg",    -3,    5,  -7,  2, 0,  0,  0,    -62,   0);
        run_vector("shift31_neg",  -3,    5,  -7, 31, 0,  0,  0,     -1,   0);
        run_vector("shift31_pos",   3,    5,  -7, 31, 0,  0,  0,      0,   0);
        run_vector("relu_pos",      3,    5,  -7,  0, 1,  0,  0,    233,   0);
        run_vector("gaps_bp",       2,   -3,   5,  0, 0,  1,  5,    -91,   0);

        // Reset in the middle of a vector: the partial vector must vanish.
        drive_beat(1, 1);
        bus.bias     = '0;
        bus.shift    = '0;
        bus.use_relu = 1'b0;
        tick();
        tick();
        bus.in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("midrst_in_ready", int'(bus.in_ready), 0);
        tick();
        check("midrst_out_valid", int'(bus.out_valid), 0);
        reset = 1'b1;
        #1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        check("midrst_no_output", seen, 0);
        run_vector("ones_after_rst", 1, 1, 0, 0, 0, 0, 0, 16, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/neuron_stream_mac.md
Name: neuron_stream_mac

Overview:
- Parametrised, time-multiplexed successor to the fixed 16-input pipelined neuron.
- Accepts an N_INPUTS-element dot product as a stream of LANES-wide beats over a valid/ready handshake and accumulates with a bias.
- Applies a run-time arithmetic right shift, saturates to OUT_W and optionally applies ReLU.
- Presents the result on a backpressured output port. Sits between the feature/weight fetch logic and the layer sequencer.

Parameters:
- DATA_W, 8: signed width of each x and w element.
- LANES, 4: elements consumed per beat. Must divide N_INPUTS.
- N_INPUTS, 16: dot-product length. BEATS = N_INPUTS/LANES.
- ACC_W, 24: accumulator width. Must be >= 2*DATA_W + clog2(N_INPUTS) + 1.
- OUT_W, 16: signed output width.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-low reset.
- in_valid, in, 1: beat valid.
- in_ready, out, 1: beat accepted when in_valid && in_ready.
- x_vec, in, LANES*DATA_W: packed signed inputs; lane 0 in the LSBs.
- w_vec, in, LANES*DATA_W: packed signed weights; lane 0 in the LSBs.
- bias, in, DATA_W: signed bias. Sampled on the first beat only.
- shift, in, 5: right-shift amount. Sampled on the first beat only.
- use_relu, in, 1: clamp negatives to 0. Sampled on the first beat only.
- out_valid, out, 1: result valid.
- out_ready, in, 1: downstream accept.
- out_data, out, OUT_W: signed result.
- out_sat, out, 1: set when saturation occurred for this result.

Behaviour:
- Reset: when reset=0 at a clock edge, all state clears.
  - FSM goes to ACCUM; beat counter = 0.
  - Pipeline valids = 0; accumulator = 0.
  - out_valid = 0, out_data = 0, out_sat = 0, in_ready = 0 during reset.
  - Any partial vector is discarded. No output is produced for it.
- FSM states:
  - ACCUM: in_ready = 1. Each accepted beat increments beat_cnt. The beat with beat_cnt == BEATS-1 is marked last, beat_cnt wraps to 0, and the FSM goes to FLUSH.
  - FLUSH: in_ready = 0. Waits until the last beat's product has entered the accumulator and the result register is loaded, then goes to HOLD.
  - HOLD: out_valid = 1 and out_data/out_sat are stable. On out_ready = 1 the FSM goes to ACCUM; in_ready rises on the following cycle. out_valid never drops without a handshake.
- Gaps: in_valid may deassert between beats in ACCUM. The counter and accumulator hold.
- Stage 1 (registered, per accepted beat):
  - Each lane computes a full-precision signed product (2*DATA_W).
  - Lane products are summed into a lane sum of width 2*DATA_W + clog2(LANES). The sum is registered together with first/last flags.
- Stage 2 (accumulator):
  - On a first-beat lane sum: acc = sext(bias) + lanesum.
  - Otherwise: acc = acc + lanesum.
  - Given the ACC_W constraint, no overflow is possible.
  - bias, shift and use_relu are captured into holding registers with the first beat.
- Stage 3 (result register, loaded one cycle after the last accumulation):
  - s = acc >>> shift (arithmetic shift, rounding toward -inf). shift >= ACC_W yields 0 or -1.
  - Saturate s to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_sat = 1 if clamping occurred.
  - If use_relu and the saturated value is negative, out_data = 0. out_sat keeps the saturation flag.
- Latency: with back-to-back beats and out_ready held high, out_valid rises 3 clock edges after the edge that accepts the last beat.
- Throughput: one vector per BEATS+4 cycles with no backpressure.
- out_ready asserted while out_valid = 0 has no effect.
- The next vector's first beat cannot be accepted in the cycle of the output handshake.

Decomposition:
- Shared package neuron_pkg holds:
  - state encoding (ACCUM, FLUSH, HOLD);
  - the saturation helper function (value, in width, out width → clamped value and flag);
  - the localparam formulas for BEATS and lane-sum width;
  - elaboration-time checks on N_INPUTS % LANES and the ACC_W minimum.
- One sub-module, lane_dot, is natural: LANES signed multipliers plus the adder tree, purely combinational, instantiated once for stage 1.

Test Plan:
- Ones vector: DATA_W=8, LANES=4, N=16. All x=1, w=1, bias=0, shift=0, relu=0, 4 back-to-back beats → out_data=16, out_sat=0, out_valid 3 edges after the last beat.
- Positive saturation: all x=127, w=127, bias=127 → raw 258191 → out_data=32767, out_sat=1.
- Negative saturation with ReLU: all x=-128, w=127. relu=0 → out_data=-32768, out_sat=1. relu=1 → out_data=0, out_sat=1.
- Shift with bias: all x=3, w=5, bias=-7, shift=2 → 233>>>2 = 58. Repeat with x=-3 (acc=-247) → -62.
- Backpressure and gaps: in_valid toggles 1/0 across beats and out_ready is held 0 for 5 cycles after out_valid. Required: out_data stable, in_ready=0 throughout, a single result after out_ready=1, and in_ready=1 on the next cycle.
- Reset mid-vector: assert reset=0 for one cycle after 2 beats; out_valid must not assert. A fresh ones vector afterwards → 16.
